jt900h_divctl: RTL and testbench

// Sequencer directly upstream of jt900h_div: accepts a DIV/DIVS request from the ALU.

---
 rtl/jt900h_divctl.sv | 224 ++++++++++++++++++++++
 tb/tb_jt900h_divctl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_divctl.sv
// -----------------------------------------------------------------------------
// jt900h_divctl
// Control sequencer that sits in front of the unsigned divider jt900h_div.
// It accepts a DIV/DIVS request, hands the divider operand magnitudes, runs the
// start/busy handshake, then restores signs, applies the signed quotient range
// rules and packs {remainder, quotient} (or the untouched dividend on overflow)
// together with the V flag.
//
// Optional feature (compile-time macro JT900H_DIVCTL_ZERO_EN):
//   defined   - a zero divisor is caught in IDLE; the divider is never started
//               and the request finishes through FIX with v=1.
//   undefined - a zero divisor is sent to the divider, which flags it on div_v.
//
// Ports
//   rst, clk, cen     : sync active-high reset, clock, clock enable
//   req, sgn, len     : request pulse, signed op (DIVS), word op (32/16)
//   op0[31:0]         : dividend          op1[15:0] : divisor
//   div_op0/div_op1   : operand magnitudes to the divider
//   div_len/div_start : size and start strobe to the divider
//   div_quot/div_rem  : divider quotient/remainder (unsigned)
//   div_busy/div_v    : divider busy and divider overflow/zero flag
//   result[31:0], v   : packed result and overflow flag
//   busy, done        : operation in flight / one cen-cycle completion pulse
// -----------------------------------------------------------------------------
module jt900h_divctl (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        req,
    input  logic        sgn,
    input  logic        len,
    input  logic [31:0] op0,
    input  logic [15:0] op1,
    output logic [31:0] div_op0,
    output logic [15:0] div_op1,
    output logic        div_len,
    output logic        div_start,
    input  logic [15:0] div_quot,
    input  logic [15:0] div_rem,
    input  logic        div_busy,
    input  logic        div_v,
    output logic [31:0] result,
    output logic        v,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sgn_q, sgn_d;
    logic        len_q, len_d;
    logic        neg0_q, neg0_d;     // dividend negative (signed ops only)
    logic        neg1_q, neg1_d;     // divisor negative (signed ops only)
    logic [31:0] dvd_q, dvd_d;       // dividend as written back on overflow
    logic [31:0] dop0_q, dop0_d;
    logic [15:0] dop1_q, dop1_d;
    logic        dlen_q, dlen_d;
    logic [31:0] result_q, result_d;
    logic        v_q, v_d;
`ifdef JT900H_DIVCTL_ZERO_EN
    logic        zero_q, zero_d;
`endif

    // Conditional two's complement negation. Negating the most negative value
    // yields the same bit pattern, which read as unsigned is the exact magnitude.
    function automatic logic [31:0] cneg32(input logic [31:0] x, input logic neg);
        logic signed [31:0] xs;
        xs = $signed(x);
        return neg ? 32'(-xs) : x;
    endfunction

    function automatic logic [15:0] cneg16(input logic [15:0] x, input logic neg);
        logic signed [15:0] xs;
        xs = $signed(x);
        return neg ? 16'(-xs) : x;
    endfunction

    function automatic logic [7:0] cneg8(input logic [7:0] x, input logic neg);
        logic signed [7:0] xs;
        xs = $signed(x);
        return neg ? 8'(-xs) : x;
    endfunction

    // Signed quotient range check on the magnitude: the negative side allows one
    // more count (-128 / -32768) than the positive side.
    function automatic logic q_ovf(input logic is_sgn, input logic is_word,
                                   input logic neg, input logic [15:0] mag);
        logic [15:0] lim;
        if (!is_sgn) return 1'b0;
        lim = is_word ? 16'h7FFF : 16'h007F;
        return mag > (lim + {15'h0, neg});
    endfunction

    // Request-side operand conditioning
    logic        op0_neg, op1_neg;
    logic [31:0] op0_mag;
    logic [15:0] op1_mag;

    assign op0_neg = sgn & (len ? op0[31] : op0[15]);
    assign op1_neg = sgn & (len ? op1[15] : op1[7]);
    assign op0_mag = len ? cneg32(op0, op0_neg)
                         : {16'h0, cneg16(op0[15:0], op0_neg)};
    assign op1_mag = len ? cneg16(op1, op1_neg)
                         : {8'h0, cneg8(op1[7:0], op1_neg)};

    // Result-side sign correction and packing
    logic [15:0] q_mag, r_mag, q_fix, r_fix;
    logic        fix_v;
    logic [31:0] fix_res;

    assign q_mag = len_q ? div_quot : {8'h0, div_quot[7:0]};
    assign r_mag = len_q ? div_rem  : {8'h0, div_rem[7:0]};
    assign q_fix = cneg16(q_mag, neg0_q ^ neg1_q);
    assign r_fix = cneg16(r_mag, neg0_q);   // remainder takes the dividend sign

`ifdef JT900H_DIVCTL_ZERO_EN
    assign fix_v = zero_q | div_v | q_ovf(sgn_q, len_q, neg0_q ^ neg1_q, q_mag);
`else
    assign fix_v = div_v | q_ovf(sgn_q, len_q, neg0_q ^ neg1_q, q_mag);
`endif

    assign fix_res = fix_v ? dvd_q :
                     len_q ? {r_fix, q_fix} : {16'h0, r_fix[7:0], q_fix[7:0]};

    always_comb begin
        state_d  = state_q;
        sgn_d    = sgn_q;
        len_d    = len_q;
        neg0_d   = neg0_q;
        neg1_d   = neg1_q;
        dvd_d    = dvd_q;
        dop0_d   = dop0_q;
        dop1_d   = dop1_q;
        dlen_d   = dlen_q;
        result_d = result_q;
        v_d      = v_q;
`ifdef JT900H_DIVCTL_ZERO_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    sgn_d  = sgn;
                    len_d  = len;
                    neg0_d = op0_neg;
                    neg1_d = op1_neg;
                    dvd_d  = len ? op0 : {16'h0, op0[15:0]};
                    dop0_d = op0_mag;
                    dop1_d = op1_mag;
                    dlen_d = len;
`ifdef JT900H_DIVCTL_ZERO_EN
                    zero_d  = (op1_mag == 16'h0);
                    state_d = (op1_mag == 16'h0) ? S_FIX : S_ISSUE;
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: state_d = S_ARM;
            // The divider raises busy one cycle after start, so ARM does not look at it.
            S_ARM:   state_d = S_WAIT;
            S_WAIT:  if (!div_busy) state_d = S_FIX;
            S_FIX: begin
                result_d = fix_res;
                v_d      = fix_v;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sgn_q    <= 1'b0;
            len_q    <= 1'b0;
            neg0_q   <= 1'b0;
            neg1_q   <= 1'b0;
            dvd_q    <= 32'h0;
            dop0_q   <= 32'h0;
            dop1_q   <= 16'h0;
            dlen_q   <= 1'b0;
            result_q <= 32'h0;
            v_q      <= 1'b0;
`ifdef JT900H_DIVCTL_ZERO_EN
            zero_q   <= 1'b0;
`endif
        end else if (cen) begin
            state_q  <= state_d;
            sgn_q    <= sgn_d;
            len_q    <= len_d;
            neg0_q   <= neg0_d;
            neg1_q   <= neg1_d;
            dvd_q    <= dvd_d;
            dop0_q   <= dop0_d;
            dop1_q   <= dop1_d;
            dlen_q   <= dlen_d;
            result_q <= result_d;
            v_q      <= v_d;
`ifdef JT900H_DIVCTL_ZERO_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign div_op0   = dop0_q;
    assign div_op1   = dop1_q;
    assign div_len   = dlen_q;
    assign div_start = (state_q == S_ISSUE);
    assign result    = result_q;
    assign v         = v_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_jt900h_divctl.sv
module tb_jt900h_divctl;

    logic        rst = 1'b1, clk = 1'b0, cen = 1'b1, req = 1'b0, sgn = 1'b0, len = 1'b0;
    logic [31:0] op0 = 32'h0;
    logic [15:0] op1 = 16'h0;
    logic [31:0] div_op0;
    logic [15:0] div_op1;
    logic        div_len, div_start;
    logic [15:0] div_quot = 16'h0, div_rem = 16'h0;
    logic        div_busy = 1'b0, div_v = 1'b0;
    logic [31:0] result;
    logic        v, busy, done;

    int n_assert = 0;
    int n_fail   = 0;
    bit cen_rnd  = 1'b0;
    bit noise    = 1'b0;
    bit lat_rnd  = 1'b0;
    logic [32:0] sb_q[$];

    jt900h_divctl dut (
        .rst(rst), .clk(clk), .cen(cen), .req(req), .sgn(sgn), .len(len),
        .op0(op0), .op1(op1),
        .div_op0(div_op0), .div_op1(div_op1), .div_len(div_len), .div_start(div_start),
        .div_quot(div_quot), .div_rem(div_rem), .div_busy(div_busy), .div_v(div_v),
        .result(result), .v(v), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Unsigned divider stand-in: {v, rem, quot}
    function automatic logic [32:0] udiv(input logic [31:0] a, input logic [15:0] b, input logic l);
        logic [31:0] q, r;
        if (b == 16'h0) return {1'b1, 32'h0};
        q = a / {16'h0, b};
        r = a % {16'h0, b};
        return {(l ? (q > 32'hFFFF) : (q > 32'hFF)), r[15:0], q[15:0]};
    endfunction

    // Divider behaviour: busy one cycle after start, garbage outputs while busy
    int          dcnt = 0;
    logic [32:0] dres = 33'h0;
    always @(posedge clk) begin
        if (rst) begin
            div_busy <= 1'b0;
            dcnt     <= 0;
        end else if (cen) begin
            if (div_start) begin
                dres     <= udiv(div_op0, div_op1, div_len);
                div_quot <= 16'($urandom);
                div_rem  <= 16'($urandom);
                div_v    <= 1'b0;
                div_busy <= 1'b1;
                dcnt     <= lat_rnd ? int'($urandom_range(1, 8)) : 5;
            end else if (div_busy) begin
                if (dcnt <= 1) begin
                    div_busy <= 1'b0;
                    {div_v, div_rem, div_quot} <= dres;
                end
                dcnt <= dcnt - 1;
            end
        end
    end

    // Reference: {v, result} from the architectural definition of DIV/DIVS
    function automatic logic [32:0] ref_div(input logic s, input logic l,
                                            input logic [31:0] a, input logic [15:0] b);
        longint na, nb, q, r;
        logic   vv;
        if (l) begin
            na = s ? longint'($signed(a)) : longint'(a);
            nb = s ? longint'($signed(b)) : longint'(b);
        end else begin
            na = s ? longint'($signed(a[15:0])) : longint'(a[15:0]);
            nb = s ? longint'($signed(b[7:0]))  : longint'(b[7:0]);
        end
        q = 0;
        r = 0;
        if (nb == 0) vv = 1'b1;
        else begin
            q = na / nb;
            r = na % nb;
            if (l) vv = s ? (q < -32768 || q > 32767) : (q > 65535);
            else   vv = s ? (q < -128   || q > 127)   : (q > 255);
        end
        if (vv) return {1'b1, (l ? a : {16'h0, a[15:0]})};
        return {1'b0, (l ? {r[15:0], q[15:0]} : {16'h0, r[7:0], q[7:0]})};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cen = cen_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic s, input logic l, input logic [31:0] a,
                          input logic [15:0] b, input logic [32:0] exp);
        sgn = s;
        len = l;
        op0 = a;
        op1 = b;
        req = 1'b1;
        cen = 1'b1;
        sb_q.push_back(exp);
        step();
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int          n;
        logic [32:0] e;
        n = 0;
        while (!done && n < budget) begin
            if (noise) begin
                req = ($urandom_range(0, 3) == 0);
                op0 = $urandom;
                op1 = 16'($urandom);
                sgn = 1'($urandom);
                len = 1'($urandom);
            end
            step();
            n++;
        end
        chk({tag, " done"}, 64'(done), 64'd1);
        if (done) begin
            chk({tag, " busy@done"}, 64'(busy), 64'd0);
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 33'bx;
            chk({tag, " v/result"}, {31'h0, v, result}, {31'h0, e});
            req = noise;          // a request alongside done must be dropped
            n = 0;
            while (done && n < budget) begin
                step();
                req = 1'b0;
                n++;
            end
            chk({tag, " idle after done"}, 64'({busy, done}), 64'd0);
        end else begin
            req = 1'b0;
            if (sb_q.size() != 0) sb_q.delete(0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("rst result",    64'(result),    64'd0);
        chk("rst v",         64'(v),         64'd0);
        chk("rst busy",      64'(busy),      64'd0);
        chk("rst done",      64'(done),      64'd0);
        chk("rst div_start", 64'(div_start), 64'd0);
        chk("rst div_op0",   64'(div_op0),   64'd0);
        chk("rst div_op1",   64'(div_op1),   64'd0);
        chk("rst div_len",   64'(div_len),   64'd0);
        rst = 1'b0;
        step();

        // DIV byte 125/7
        do_req(1'b0, 1'b0, 32'h0000_007D, 16'h0007, {1'b0, 32'h0000_0611});
        chk("div8 busy", 64'(busy), 64'd1);
        chk("div8 start", 64'(div_start), 64'd1);
        step();
        chk("div8 start once", 64'(div_start), 64'd0);
        wait_done("div8 125/7", 100);

        // DIVS word -125/7
        do_req(1'b1, 1'b1, 32'hFFFF_FF83, 16'h0007, {1'b0, 32'hFFFA_FFEF});
        chk("divs16 op0 mag", 64'(div_op0), 64'h7D);
        chk("divs16 op1 mag", 64'(div_op1), 64'h7);
        chk("divs16 len", 64'(div_len), 64'd1);
        wait_done("divs16 -125/7", 100);

        // DIVS byte -125/7 with junk in the ignored upper bits
        do_req(1'b1, 1'b0, 32'h1234_FF83, 16'hAB07, {1'b0, 32'h0000_FAEF});
        chk("divs8 op0 mag", 64'(div_op0), 64'h7D);
        chk("divs8 op1 mag", 64'(div_op1), 64'h7);
        chk("divs8 len", 64'(div_len), 64'd0);
        wait_done("divs8 -125/7", 100);

        // Signed range edges and overflow
        do_req(1'b1, 1'b0, 32'h0000_FF00, 16'h0002, {1'b0, 32'h0000_0080});
        wait_done("divs8 -256/2", 100);
        do_req(1'b1, 1'b0, 32'h0000_0080, 16'h0001, {1'b1, 32'h0000_0080});
        wait_done("divs8 128/1 ovf", 100);
        do_req(1'b1, 1'b1, 32'hFFFF_8000, 16'h0001, {1'b0, 32'h0000_8000});
        wait_done("divs16 -32768/1", 100);
        do_req(1'b0, 1'b0, 32'h0000_1000, 16'h0001, {1'b1, 32'h0000_1000});
        wait_done("div8 0x1000/1 ovf", 100);
        do_req(1'b1, 1'b1, 32'h0001_0000, 16'h0002, {1'b1, 32'h0001_0000});
        wait_done("divs16 0x10000/2 ovf", 100);
        do_req(1'b1, 1'b1, 32'h8000_0000, 16'h8000, {1'b1, 32'h8000_0000});
        wait_done("divs16 msb/msb ovf", 100);
        do_req(1'b1, 1'b0, 32'h0000_8000, 16'h00FF, {1'b1, 32'h0000_8000});
        wait_done("divs8 -32768/-1 ovf", 100);

        // Zero divisor
`ifdef JT900H_DIVCTL_ZERO_EN
        do_req(1'b0, 1'b1, 32'h1234_5678, 16'h0000, {1'b1, 32'h1234_5678});
        chk("zero start lo", 64'(div_start), 64'd0);
        chk("zero done early", 64'(done), 64'd0);
        step();
        chk("zero done at 2", 64'(done), 64'd1);
        chk("zero start lo2", 64'(div_start), 64'd0);
        wait_done("div16 /0", 0);
`else
        do_req(1'b0, 1'b1, 32'h1234_5678, 16'h0000, {1'b1, 32'h1234_5678});
        wait_done("div16 /0", 100);
`endif
        do_req(1'b1, 1'b0, 32'hABCD_1234, 16'hFF00, {1'b1, 32'h0000_1234});
        wait_done("divs8 /0", 100);

        // Reset while waiting on the divider
        do_req(1'b0, 1'b1, 32'h0000_0100, 16'h0003, {1'b0, 32'h0001_0055});
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst busy",   64'(busy),      64'd0);
        chk("midrst done",   64'(done),      64'd0);
        chk("midrst result", 64'(result),    64'd0);
        chk("midrst v",      64'(v),         64'd0);
        chk("midrst start",  64'(div_start), 64'd0);
        rst = 1'b0;
        sb_q.delete();
        step();
        do_req(1'b0, 1'b0, 32'h0000_007D, 16'h0007, {1'b0, 32'h0000_0611});
        wait_done("post-rst 125/7", 100);

        // Randomised traffic with gated cen, random latency and stray requests
        cen_rnd = 1'b1;
        noise   = 1'b1;
        lat_rnd = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            logic        s, l;
            logic [31:0] a;
            logic [15:0] b;
            s = 1'($urandom);
            l = 1'($urandom);
            a = $urandom;
            b = 16'($urandom);
            case ($urandom_range(0, 4))
                0: b = 16'($urandom_range(0, 2));
                1: a = a >> $urandom_range(8, 31);
                2: b = {8'hFF, 8'($urandom_range(0, 255))};
                3: begin
                    a = l ? 32'h8000_0000 : {16'($urandom), 16'h8000};
                    b = 16'hFFFF;
                end
                default: ;
            endcase
            do_req(s, l, a, b, ref_div(s, l, a, b));
            wait_done("rand", 200);
        end
        cen_rnd = 1'b0;
        noise   = 1'b0;
        req     = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
